// File: rtl/imem_loader.sv
// Instruction-memory loader: parses a framed host byte stream and writes big-endian words into imem.
// Optional trailing XOR checksum byte is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned MAX_WORDS = 4096,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [ADDR_W-1:0] load_address,
  output logic [31:0]       load_data,
  output logic              load_wren,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERROR
`ifdef IMEM_LOADER_CHECKSUM_EN
    , S_CHK
`endif
  } state_t;

  state_t      state, state_next;
  logic [15:0] count;
  logic [15:0] word_cnt;
  logic [15:0] word_cnt_inc;
  logic [15:0] len_full;
  logic [1:0]  byte_idx;
  logic        accept;
  logic        is_sync;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]  csum;
`endif

  assign accept       = rx_valid && rx_ready;
  assign is_sync      = (rx_data == SYNC_BYTE);
  assign word_cnt_inc = word_cnt + 16'd1;
  assign len_full     = {count[15:8], rx_data};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      count        <= '0;
      word_cnt     <= '0;
      byte_idx     <= '0;
      load_address <= '0;
      load_data    <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      csum         <= '0;
`endif
    end else begin
      state <= state_next;
      case (state)
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_IDLE, S_DONE: if (accept && is_sync) csum <= '0;
`endif
        S_LEN_HI: if (accept) count[15:8] <= rx_data;
        S_LEN_LO: begin
          if (accept) begin
            count[7:0]   <= rx_data;
            load_address <= '0;
            byte_idx     <= '0;
            word_cnt     <= '0;
          end
        end
        S_DATA: begin
          if (accept) begin
            load_data <= {load_data[23:0], rx_data};
            byte_idx  <= byte_idx + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum      <= csum ^ rx_data;
`endif
          end
        end
        // Address wraps to 0 after the final word of a full-size image; that write has already happened.
        S_WRITE: begin
          load_address <= load_address + ADDR_W'(1);
          word_cnt     <= word_cnt_inc;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    rx_ready   = (state != S_WRITE);
    load_wren  = (state == S_WRITE);
    done       = (state == S_DONE);
    error      = (state == S_ERROR);
    cpu_hold   = (state != S_IDLE) && (state != S_DONE);
    case (state)
      S_IDLE:   if (accept && is_sync) state_next = S_LEN_HI;
      S_LEN_HI: if (accept) state_next = S_LEN_LO;
      S_LEN_LO: begin
        if (accept) begin
          if (len_full == 16'd0)
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_next = S_CHK;
`else
            state_next = S_DONE;
`endif
          else if (32'(len_full) > MAX_WORDS)
            state_next = S_ERROR;
          else
            state_next = S_DATA;
        end
      end
      S_DATA:   if (accept && byte_idx == 2'd3) state_next = S_WRITE;
      S_WRITE: begin
        if (word_cnt_inc == count)
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_next = S_CHK;
`else
          state_next = S_DONE;
`endif
        else
          state_next = S_DATA;
      end
      S_DONE:   if (accept && is_sync) state_next = S_LEN_HI;
      S_ERROR:  state_next = S_ERROR;
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHK:    if (accept) state_next = (rx_data == csum) ? S_DONE : S_ERROR;
`endif
      default:  state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed and random frames against a frame-level reference model.
module tb_imem_loader;
  localparam int unsigned AW   = 12;
  localparam int unsigned MAXW = 4096;
  localparam int ST_DONE = 1;
  localparam int ST_ERR  = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [7:0]    rx_data = '0;
  logic          rx_valid = 1'b0;
  logic          rx_ready;
  logic [AW-1:0] load_address;
  logic [31:0]   load_data;
  logic          load_wren, cpu_hold, done, error;

  int total = 0;
  int bad   = 0;
  logic [AW+31:0] got_q[$];
  logic [AW+31:0] exp_q[$];
  logic [7:0]     fr[$];

  imem_loader #(.ADDR_W(AW), .MAX_WORDS(MAXW), .SYNC_BYTE(8'hA5)) dut (
    .clock(clock), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .load_address(load_address), .load_data(load_data), .load_wren(load_wren),
    .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  always #5 clock = ~clock;

  always @(negedge clock) if (load_wren === 1'b1) got_q.push_back({load_address, load_data});

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, output int stalls);
    stalls = 0;
    @(negedge clock);
    rx_data  = b;
    rx_valid = 1'b1;
    while (rx_ready !== 1'b1 && stalls < 8) begin
      @(negedge clock);
      stalls++;
    end
    if (stalls >= 8) begin
      check("rx_timeout", 64'(stalls), 64'd0);
      rx_valid = 1'b0;
    end else begin
      @(posedge clock);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    rx_valid = 1'b0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic append_csum(input int cnt);
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] x = '0;
    int s = 0;
    while (fr[s] != 8'hA5) s++;
    for (int i = 0; i < 4 * cnt; i++) x ^= fr[s + 3 + i];
    fr.push_back(x);
`else
    if (cnt < 0) fr.delete();
`endif
  endtask

  task automatic build_frame(input int cnt, input int ngarb);
    logic [7:0] b;
    logic [15:0] c16;
    fr.delete();
    for (int g = 0; g < ngarb; g++) begin
      b = 8'($urandom_range(0, 255));
      if (b == 8'hA5) b = 8'h5A;
      fr.push_back(b);
    end
    c16 = 16'(cnt);
    fr.push_back(8'hA5);
    fr.push_back(c16[15:8]);
    fr.push_back(c16[7:0]);
    if (cnt <= int'(MAXW)) begin
      for (int i = 0; i < 4 * cnt; i++) fr.push_back(8'($urandom_range(0, 255)));
      append_csum(cnt);
    end
  endtask

  // Reference: parse the whole frame at once and derive the writes and the final status.
  task automatic model(output int st);
    int i = 0;
    int cnt;
    logic [7:0]  x = '0;
    logic [31:0] word;
    while (fr[i] != 8'hA5) i++;
    cnt = int'({fr[i+1], fr[i+2]});
    if (cnt > int'(MAXW)) begin
      st = ST_ERR;
    end else begin
      for (int w = 0; w < cnt; w++) begin
        word = {fr[i+3+4*w], fr[i+4+4*w], fr[i+5+4*w], fr[i+6+4*w]};
        x ^= word[31:24] ^ word[23:16] ^ word[15:8] ^ word[7:0];
        exp_q.push_back({AW'(w % (1 << AW)), word});
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      st = (fr[i + 3 + 4 * cnt] == x) ? ST_DONE : ST_ERR;
`else
      st = ST_DONE;
`endif
    end
  endtask

  task automatic send_frame(input int gap_pct);
    int s = 0;
    int cnt, stalls, d, st, exp_stall;
    bit gap;
    while (fr[s] != 8'hA5) s++;
    cnt = int'({fr[s+1], fr[s+2]});
    for (int k = 0; k < fr.size(); k++) begin
      gap = 1'b0;
      if (k > s + 1 && gap_pct > 0 && int'($urandom_range(0, 99)) < gap_pct) begin
        @(negedge clock);
        rx_valid = 1'b0;
        gap = 1'b1;
      end
      send_byte(fr[k], stalls);
      d = k - (s + 3);
      exp_stall = (!gap && d >= 4 && (d % 4) == 0 && cnt >= 1 && cnt <= int'(MAXW) && d / 4 <= cnt) ? 1 : 0;
      check("stall", 64'(stalls), 64'(exp_stall));
      if (k == s) begin
        @(negedge clock);
        rx_valid = 1'b0;
        check("hold_after_sync", {61'd0, cpu_hold, done, error}, 64'b100);
      end
    end
    @(negedge clock);
    rx_valid = 1'b0;
    @(negedge clock);
    model(st);
    check("n_writes", 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check("write", 64'(got_q[i]), 64'(exp_q[i]));
    check("status", {61'd0, cpu_hold, done, error}, (st == ST_DONE) ? 64'b010 : 64'b101);
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int stalls;
    #1;
    check("reset_ctl", {59'd0, rx_ready, load_wren, cpu_hold, done, error}, 64'b10000);
    check("reset_addr", 64'(load_address), 64'd0);
    check("reset_data", 64'(load_data), 64'd0);
    @(negedge clock);
    reset = 1'b1;

    // Basic two-word load, back-to-back bytes so the second word hits the WRITE stall.
    fr = '{8'hA5, 8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67};
    append_csum(2);
    send_frame(0);

    // Garbage then empty frame.
    fr = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00};
    append_csum(0);
    send_frame(0);

    for (int n = 0; n < 10; n++) begin
      build_frame(int'($urandom_range(1, 6)), int'($urandom_range(0, 2)));
      send_frame(30);
    end

    // Full-size image: the address wraps back to 0 after the last word.
    build_frame(int'(MAXW), 0);
    send_frame(0);
    check("wrap_addr", 64'(load_address), 64'd0);

    // Reset mid-word: outputs clear without a clock edge, then a fresh load starts at address 0.
    fr = '{8'hA5, 8'h00, 8'h01, 8'h11, 8'h22};
    for (int k = 0; k < fr.size(); k++) send_byte(fr[k], stalls);
    #2;
    reset = 1'b0;
    #1;
    check("async_reset", {load_address, load_data, load_wren, cpu_hold, done, error}, 64'd0);
    check("no_write_before_reset", 64'(got_q.size()), 64'd0);
    @(negedge clock);
    rx_valid = 1'b0;
    reset = 1'b1;
    build_frame(3, 0);
    send_frame(20);

`ifdef IMEM_LOADER_CHECKSUM_EN
    fr = '{8'hA5, 8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
    send_frame(0);
    fr = '{8'hA5, 8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h09};
    send_frame(0);
    do_reset();
`endif

    // Oversize count: error, bytes drained, reset clears.
    fr = '{8'hA5, 8'h10, 8'h01};
    send_frame(0);
    for (int k = 0; k < 3; k++) begin
      send_byte(8'($urandom_range(0, 255)), stalls);
      check("drain_stall", 64'(stalls), 64'd0);
    end
    @(negedge clock);
    rx_valid = 1'b0;
    check("err_sticky", {61'd0, cpu_hold, error, load_wren}, 64'b110);
    check("err_no_write", 64'(got_q.size()), 64'd0);
    do_reset();
    #1;
    check("err_cleared", {61'd0, cpu_hold, done, error}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
